// File: rtl/comp_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | comp_seq_ctrl: MSB-first 2-bit-slice magnitude compare, one-hot result.   |
// | Option: COMP_FULL_SCAN_EN (no early exit, constant N-cycle latency).      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module comp_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [2:0]       res
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] c_last_slice = CW'(N - 1);

  localparam logic [2:0] c_res_eq = 3'b001;
  localparam logic [2:0] c_res_gt = 3'b010;
  localparam logic [2:0] c_res_lt = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [2:0]       r_res;
`ifdef COMP_FULL_SCAN_EN
  logic [1:0]       r_dec;   // sticky {lt,gt} from the first unequal slice
`endif

  logic [1:0] w_top_a;
  logic [1:0] w_top_b;
  logic       w_gt;
  logic       w_lt;

  assign w_top_a = r_a[WIDTH-1 -: 2];
  assign w_top_b = r_b[WIDTH-1 -: 2];
  assign w_gt    = (w_top_a > w_top_b);
  assign w_lt    = (w_top_a < w_top_b);

  assign busy = r_busy;
  assign done = r_done;
  assign res  = r_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_res   <= 3'b000;
`ifdef COMP_FULL_SCAN_EN
      r_dec   <= 2'b00;
`endif
    end else begin
      case (r_state)
        S_CMP: begin
`ifdef COMP_FULL_SCAN_EN
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (r_dec[0] || (r_dec == 2'b00 && w_gt))
              r_res <= c_res_gt;
            else if (r_dec[1] || (r_dec == 2'b00 && w_lt))
              r_res <= c_res_lt;
            else
              r_res <= c_res_eq;
          end else begin
            if (r_dec == 2'b00)
              r_dec <= {w_lt, w_gt};
            r_a   <= r_a << 2;
            r_b   <= r_b << 2;
            r_cnt <= r_cnt - 1'b1;
          end
`else
          if (w_gt || w_lt || r_cnt == '0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_res   <= w_gt ? c_res_gt : (w_lt ? c_res_lt : c_res_eq);
          end else begin
            r_a   <= r_a << 2;
            r_b   <= r_b << 2;
            r_cnt <= r_cnt - 1'b1;
          end
`endif
        end
        default: begin
          // IDLE and DONE both accept; DONE->CMP gives back-to-back compares
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_CMP;
            r_busy  <= 1'b1;
            r_a     <= a;
            r_b     <= b;
            r_cnt   <= c_last_slice;
            r_res   <= 3'b000;
`ifdef COMP_FULL_SCAN_EN
            r_dec   <= 2'b00;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_comp_seq_ctrl.sv
`default_nettype none
// Bench for comp_seq_ctrl (WIDTH=8): directed vectors plus a per-cycle
// comparison against a transaction-level model.
module tb_comp_seq_ctrl;

  localparam int W = 8;
  localparam int N = W / 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [2:0]   res;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  bit check_en = 1'b0;

  comp_seq_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .res  (res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Result from plain magnitude compare; latency = slices up to first difference.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [2:0] r, output int k);
    logic [W-1:0] xs, ys;
    r  = (x > y) ? 3'b010 : ((x < y) ? 3'b100 : 3'b001);
    k  = N;
    xs = x;
    ys = y;
    for (int i = 0; i < N; i++) begin
      if (xs[W-1 -: 2] != ys[W-1 -: 2]) begin
        k = i + 1;
        break;
      end
      xs = xs << 2;
      ys = ys << 2;
    end
`ifdef COMP_FULL_SCAN_EN
    k = N;
`endif
  endfunction

  int         m_rem = 0;
  logic [2:0] m_pend = 3'b000;
  logic [2:0] m_res = 3'b000;
  logic       m_done = 1'b0;

  always @(posedge clk) begin
    int k;
    if (rst) begin
      m_rem  = 0;
      m_res  = 3'b000;
      m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1'b1;
        m_res  = m_pend;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        model(a, b, m_pend, k);
        m_rem = k;
        m_res = 3'b000;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", busy, m_rem > 0);
      chk("done", done, m_done);
      chk("res", res, m_res);
      chk("busy_done_excl", busy & done, 1'b0);
      if (done) done_cnt++;
    end
  end

  // Pulse start for one edge, then measure cycles until done and check result.
  task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [2:0] er, input int ek, input string nm);
    int cyc;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_lat"}, cyc, ek);
    chk({nm, "_res"}, res, er);
  endtask

  initial begin
    logic [2:0] mr;
    int mk, cyc, dc0;
    int k_c0_40, k_00_ff;
`ifdef COMP_FULL_SCAN_EN
    k_c0_40 = 4; k_00_ff = 4;
`else
    k_c0_40 = 1; k_00_ff = 1;
`endif

    // model pinned by hand-computed values
    model(8'hC0, 8'h40, mr, mk);
    chk("model_c0_40_res", mr, 3'b010);
    chk("model_c0_40_k", mk, k_c0_40);
    model(8'h12, 8'h13, mr, mk);
    chk("model_12_13_res", mr, 3'b100);
    chk("model_12_13_k", mk, 4);
    model(8'hA5, 8'hA5, mr, mk);
    chk("model_a5_res", mr, 3'b001);
    chk("model_a5_k", mk, 4);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_en = 1'b1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_res", res, 3'b000);
    rst = 1'b0;

    run_one(8'hA5, 8'hA5, 3'b001, 4, "t1_eq");
    run_one(8'hC0, 8'h40, 3'b010, k_c0_40, "t2_gt");
    run_one(8'h12, 8'h13, 3'b100, 4, "t3_lt_last");
    run_one(8'h00, 8'hFF, 3'b100, k_00_ff, "t3_lt_first");
    run_one(8'h40, 8'h00, 3'b010, 4 - 3 * (k_c0_40 == 1 ? 1 : 0) + 0, "t_gt_first");

    // start while busy is ignored; exactly one done pulse
    @(negedge clk);
    dc0 = done_cnt;
    a = 8'h12; b = 8'h13; start = 1'b1;
    @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t4_lat", cyc, 4);
    chk("t4_res", res, 3'b100);
    repeat (6) @(negedge clk);
    chk("t4_one_done", done_cnt - dc0, 1);

    // reset during second CMP cycle aborts with no done
    dc0 = done_cnt;
    a = 8'h12; b = 8'h13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_res", res, 3'b000);
    repeat (5) @(negedge clk);
    chk("t5_no_done", done_cnt - dc0, 0);
    run_one(8'h80, 8'h40, 3'b010, k_c0_40, "t5_after");

    // back-to-back: start held through DONE
    @(negedge clk);
    a = 8'h40; b = 8'hC0; start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_first_lat", cyc, k_c0_40);
    chk("t6_first_res", res, 3'b100);
    a = 8'h33; b = 8'h33;
    @(negedge clk);
    start = 1'b0;
    chk("t6_rebusy", busy, 1'b1);
    chk("t6_cleared", res, 3'b000);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_second_lat", cyc, 4);
    chk("t6_second_res", res, 3'b001);
    repeat (3) @(negedge clk);
    chk("t6_hold_res", res, 3'b001);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
